// File: rtl/decim_chain_seq_pkg.sv
// rtl/decim_chain_seq_pkg.sv - FilterLib types and defaults for the decimating chain sequencer
package decim_chain_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FLUSH  = 2'd1,
    SETTLE = 2'd2,
    RUN    = 2'd3
  } decim_seq_state_t;

  localparam int DECIM_SEQ_FLUSH_DEF  = 64;
  localparam int DECIM_SEQ_SETTLE_DEF = 16;

  // Address width for a power-of-2 FIFO, never narrower than one bit
  function automatic int fifo_addr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/decim_chain_seq_sync_fifo.sv
// rtl/decim_chain_seq_sync_fifo.sv - synchronous FIFO with registered head, push-when-full accepted only alongside a pop
module sync_fifo
  import decim_chain_seq_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty
);

  localparam int AW = fifo_addr_w(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              do_push;
  logic              do_pop;
  logic [AW:0]       count_after_pop;

  assign full            = (count == (AW+1)'(DEPTH));
  assign empty           = (count == '0);
  assign do_pop          = pop & ~empty;
  assign do_push         = push & (~full | do_pop);
  assign count_after_pop = count - (AW+1)'(do_pop);

  // Storage write; a cleared FIFO ignores the push of that cycle
  always_ff @(posedge clk) begin
    if (do_push && !clr) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers, occupancy and the registered head word
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_after_pop + (AW+1)'(do_push);
      // A push into an (effectively) empty FIFO becomes the head directly;
      // otherwise a pop exposes the next stored word.
      if (do_push && count_after_pop == '0) begin
        head <= din;
      end else if (do_pop) begin
        head <= mem[rd_ptr + 1'b1];
      end
    end
  end

endmodule

// File: rtl/decim_chain_seq.sv
// rtl/decim_chain_seq.sv - run-control sequencer for the decimating chain; optional watchdog via DECIM_SEQ_WATCHDOG_EN
module decim_chain_seq
  import decim_chain_seq_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int FLUSH_CYCLES   = DECIM_SEQ_FLUSH_DEF,
  parameter int SETTLE_SAMPLES = DECIM_SEQ_SETTLE_DEF,
  parameter int FIFO_DEPTH     = 4,
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              chain_rst,
  output logic              chain_ce,
  output logic [DATA_W-1:0] chain_din,
  input  logic [DATA_W-1:0] chain_dout,
  input  logic              chain_dout_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [1:0]        state,
  output logic              overrun,
  output logic              timeout,
  output logic [CNT_W-1:0]  sample_cnt
);

  localparam int FLUSH_W  = $clog2(FLUSH_CYCLES + 1);
  localparam int SETTLE_W = $clog2(SETTLE_SAMPLES + 2);

  decim_seq_state_t     state_q;
  decim_seq_state_t     state_d;
  logic [FLUSH_W-1:0]   flush_cnt;
  logic [SETTLE_W-1:0]  settle_cnt;
  logic                 stop_hit;
  logic                 start_hit;
  logic                 settle_done;
  logic                 run_push;
  logic                 push_ok;
  logic                 pop;
  logic                 wd_fire;
  logic                 fifo_full;
  logic                 fifo_empty;

  assign stop_hit    = (state_q != IDLE) & stop;
  assign start_hit   = (state_q == IDLE) & start & ~stop;
  assign settle_done = (state_q == SETTLE) & chain_dout_valid &
                       ((int'(settle_cnt) + 1) == SETTLE_SAMPLES);
  assign run_push    = (state_q == RUN) & chain_dout_valid & ~stop;
  assign pop         = m_valid & m_ready;
  assign push_ok     = run_push & (~fifo_full | pop);
  assign m_valid     = ~fifo_empty;
  assign chain_din   = s_data;
  assign state       = state_q;

`ifdef DECIM_SEQ_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;
  logic            timeout_q;
  logic            wd_armed;

  assign wd_armed = (state_q == SETTLE) | (state_q == RUN);
  assign wd_fire  = wd_armed & ~stop & ~chain_dout_valid &
                    (int'(wd_cnt) == TIMEOUT_CYCLES - 1);
  assign timeout  = timeout_q;

  // Watchdog: cycles since the last chain output while the chain should be producing
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (!wd_armed || chain_dout_valid || wd_fire) wd_cnt <= '0;
      else                                          wd_cnt <= wd_cnt + 1'b1;
      if (start_hit)    timeout_q <= 1'b0;
      else if (wd_fire) timeout_q <= 1'b1;
    end
  end
`else
  assign wd_fire = 1'b0;
  // Constant 0; the comparison only keeps the limit parameter referenced
  assign timeout = (TIMEOUT_CYCLES < 0);
`endif

  // Next-state and chain control; stop overrides watchdog recovery
  always_comb begin
    state_d   = state_q;
    chain_rst = 1'b1;
    chain_ce  = 1'b0;
    case (state_q)
      IDLE:   if (start_hit) state_d = FLUSH;
      FLUSH:  if (flush_cnt == '0) state_d = (SETTLE_SAMPLES == 0) ? RUN : SETTLE;
      SETTLE: begin
        chain_rst = 1'b0;
        chain_ce  = s_valid;
        if (settle_done) state_d = RUN;
      end
      RUN: begin
        chain_rst = 1'b0;
        chain_ce  = s_valid;
      end
      default: state_d = IDLE;
    endcase
    if (wd_fire)  state_d = FLUSH;
    if (stop_hit) state_d = IDLE;
  end

  // State register, flush/settle counters, sticky overrun and sample counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      flush_cnt  <= '0;
      settle_cnt <= '0;
      overrun    <= 1'b0;
      sample_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (start_hit || wd_fire) begin
        flush_cnt <= FLUSH_W'(FLUSH_CYCLES - 1);
      end else if (state_q == FLUSH && flush_cnt != '0) begin
        flush_cnt <= flush_cnt - 1'b1;
      end
      if (state_q != SETTLE)    settle_cnt <= '0;
      else if (chain_dout_valid) settle_cnt <= settle_cnt + 1'b1;
      if (start_hit) begin
        overrun    <= 1'b0;
        sample_cnt <= '0;
      end else begin
        if (run_push && fifo_full && !pop) overrun <= 1'b1;
        if (push_ok) sample_cnt <= sample_cnt + 1'b1;
      end
    end
  end

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (stop_hit | wd_fire),
    .push  (run_push),
    .din   (chain_dout),
    .pop   (pop),
    .head  (m_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_decim_chain_seq.sv
// tb/tb_decim_chain_seq.sv - randomized self-checking bench for decim_chain_seq against a queue-based model
module tb_decim_chain_seq;

  localparam int DW    = 32;
  localparam int FLUSH = 64;
  localparam int SETL  = 16;
  localparam int DEPTH = 4;
  localparam int CW    = 16;
  localparam int TMO   = 100;

  logic          clk = 1'b0;
  logic          rst_n, start, stop, s_valid, chain_dout_valid, m_ready;
  logic [DW-1:0] s_data, chain_dout;
  logic          chain_rst, chain_ce, m_valid, overrun, timeout;
  logic [DW-1:0] chain_din, m_data;
  logic [1:0]    state;
  logic [CW-1:0] sample_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // reference model: phase, remaining flush cycles, settle pulses seen, output queue, flags
  int            mst, flush_left, settle_seen, wd;
  int unsigned   cnt;
  bit            ovr, tmo;
  logic [DW-1:0] q[$];
  logic [DW-1:0] got[$];

  decim_chain_seq #(
    .DATA_W(DW), .FLUSH_CYCLES(FLUSH), .SETTLE_SAMPLES(SETL),
    .FIFO_DEPTH(DEPTH), .CNT_W(CW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .s_data(s_data), .s_valid(s_valid),
    .chain_rst(chain_rst), .chain_ce(chain_ce), .chain_din(chain_din),
    .chain_dout(chain_dout), .chain_dout_valid(chain_dout_valid),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .state(state), .overrun(overrun), .timeout(timeout), .sample_cnt(sample_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
    n_checks++;
    if (got_v !== exp_v) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got_v, exp_v);
    end
  endtask

  task automatic model_edge();
    bit popped;
    if (!rst_n) begin
      mst = 0; q.delete(); ovr = 0; tmo = 0; cnt = 0; wd = 0;
      return;
    end
    if (mst != 0 && stop) begin
      mst = 0; q.delete(); wd = 0;
      return;
    end
    case (mst)
      0: if (start) begin
        mst = 1; flush_left = FLUSH; ovr = 0; tmo = 0; cnt = 0;
      end
      1: begin
        flush_left--;
        if (flush_left == 0) begin
          mst = (SETL == 0) ? 3 : 2; settle_seen = 0; wd = 0;
        end
      end
      default: begin
`ifdef DECIM_SEQ_WATCHDOG_EN
        if (chain_dout_valid) wd = 0;
        else begin
          wd++;
          if (wd == TMO) begin
            tmo = 1; mst = 1; flush_left = FLUSH; q.delete(); wd = 0;
            return;
          end
        end
`endif
        if (mst == 2) begin
          if (chain_dout_valid) begin
            settle_seen++;
            if (settle_seen == SETL) mst = 3;
          end
        end else begin
          popped = (q.size() > 0) && m_ready;
          if (popped) void'(q.pop_front());
          if (chain_dout_valid) begin
            if (q.size() < DEPTH) begin
              q.push_back(chain_dout);
              cnt = (cnt + 1) % (1 << CW);
            end else begin
              ovr = 1;
            end
          end
        end
      end
    endcase
  endtask

  task automatic check_all();
    check_eq("state", state, mst);
    check_eq("chain_rst", chain_rst, mst < 2);
    check_eq("chain_ce", chain_ce, (mst >= 2) && s_valid);
    check_eq("chain_din", chain_din, s_data);
    check_eq("m_valid", m_valid, q.size() > 0);
    if (q.size() > 0) check_eq("m_data", m_data, q[0]);
    check_eq("overrun", overrun, ovr);
    check_eq("sample_cnt", sample_cnt, cnt);
    check_eq("timeout", timeout, tmo);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    s_valid = 1'($urandom);
    s_data  = $urandom;
  endtask

  task automatic pulse(input logic [DW-1:0] v);
    chain_dout = v; chain_dout_valid = 1'b1;
    tick();
    chain_dout_valid = 1'b0;
  endtask

  task automatic restart_to_run();
    stop = 1'b1; tick(); stop = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < FLUSH; i++) tick();
    for (int i = 0; i < SETL; i++) pulse($urandom);
    check_eq("reach_run", state, 3);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "bench did not finish");
  end

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; s_data = '0; s_valid = 1'b0;
    chain_dout = '0; chain_dout_valid = 1'b0; m_ready = 1'b1;
    mst = 0; cnt = 0; ovr = 0; tmo = 0; wd = 0; flush_left = 0; settle_seen = 0;
    repeat (3) tick();
    check_eq("rst_m_data", m_data, 0);
    check_eq("rst_chain_rst", chain_rst, 1);
    rst_n = 1'b1;
    tick();

    // flush length: chain_rst held for exactly FLUSH cycles after start
    start = 1'b1; tick(); start = 1'b0;
    n = 0;
    while (chain_rst && n < 200) begin
      n++;
      tick();
    end
    check_eq("flush_len", n, FLUSH);

    // settle discards 16 pulses, then 17..20 stream out
    m_ready = 1'b1;
    got.delete();
    for (int v = 1; v <= 20; v++) begin
      pulse(v);
      if (m_valid && m_ready) got.push_back(m_data);
      tick();
      if (m_valid && m_ready) got.push_back(m_data);
    end
    check_eq("settle_out_n", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++) check_eq("settle_out", got[i], 17 + i);
    check_eq("settle_cnt", sample_cnt, 4);
    check_eq("settle_state", state, 3);

    // overrun: 6 pushes into a stalled depth-4 FIFO
    restart_to_run();
    m_ready = 1'b0;
    for (int v = 1; v <= 6; v++) begin
      pulse(v);
      check_eq("stall_head", m_data, 1);
      if (v == 4) check_eq("ovr_before", overrun, 0);
      if (v == 5) check_eq("ovr_after5", overrun, 1);
    end
    check_eq("ovr_cnt", sample_cnt, 4);
    m_ready = 1'b1;
    got.delete();
    for (int i = 0; i < 10; i++) begin
      if (m_valid) got.push_back(m_data);
      tick();
    end
    check_eq("drain_n", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++) check_eq("drain", got[i], i + 1);

    // full FIFO with simultaneous push and pop
    restart_to_run();
    m_ready = 1'b0;
    for (int v = 10; v <= 13; v++) pulse(v);
    m_ready = 1'b1;
    pulse(14);
    check_eq("pp_ovr", overrun, 0);
    got.delete();
    for (int i = 0; i < 10; i++) begin
      if (m_valid) got.push_back(m_data);
      tick();
    end
    check_eq("pp_n", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++) check_eq("pp_order", got[i], 11 + i);

    // start+stop together in RUN: stop wins, flags kept; a later start clears overrun
    m_ready = 1'b0;
    for (int v = 0; v < 5; v++) pulse($urandom);
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    check_eq("ss_state", state, 0);
    check_eq("ss_chain_rst", chain_rst, 1);
    check_eq("ss_m_valid", m_valid, 0);
    check_eq("ss_ovr_kept", overrun, 1);
    start = 1'b1; tick(); start = 1'b0;
    check_eq("restart_ovr", overrun, 0);
    check_eq("restart_state", state, 1);

    // chain goes silent in RUN
    restart_to_run();
    m_ready = 1'b1;
    for (int i = 0; i < TMO + 20; i++) tick();
`ifdef DECIM_SEQ_WATCHDOG_EN
    check_eq("wd_timeout", timeout, 1);
    check_eq("wd_state", state, 1);
`else
    check_eq("wd_timeout", timeout, 0);
    check_eq("wd_state", state, 3);
`endif

    // randomized traffic with occasional start/stop/reset
    for (int i = 0; i < 3000; i++) begin
      chain_dout_valid = ($urandom % 3) == 0;
      chain_dout       = $urandom;
      m_ready          = ($urandom % 4) != 0;
      start            = ($urandom % 150) == 0;
      stop             = ($urandom % 500) == 0;
      rst_n            = ($urandom % 1500) != 0;
      if (i < 5) start = 1'b1;
      tick();
    end
    start = 1'b0; stop = 1'b0; rst_n = 1'b1; chain_dout_valid = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
